perm_unload: RTL and testbench
==============================

Name: perm_unload

Overview:
- Output-side counterpart of the permutation block's input loader.
- Once a permutation completes, it reads the 25 x 64-bit Keccak state lanes from a state memory bank and streams them on the pushout/stopout/firstout/dout interface.
- Absorbs the memory's 1-cycle read latency and downstream backpressure with a 2-entry output buffer.
- Sits between the permutation controller (start/done) and the downstream consumer.

Parameters:
- LANE_W, 64, lane width in bits (dout, mrd).
- RATE_LANES, 17, lanes emitted when PERM_UNLOAD_RATE_EN is defined (SHA3-256 rate); range 1..25.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: state memory holds final state, begin unload
- busy  out  1  unload in progress
- done  out  1  1-cycle pulse after the final beat is accepted
- mrx  out  3  state memory read x
- mry  out  3  state memory read y
- mrd  in  LANE_W  read data; valid the cycle after mrx/mry are driven
- pushout  out  1  dout valid
- stopout  in  1  downstream stall
- firstout  out  1  marks lane (0,0)
- dout  out  LANE_W  lane data

Behaviour:
- Reset (synchronous, active-high, one clk edge):
  - busy, done, pushout, firstout = 0; dout = 0; mrx, mry = 0.
  - Buffer is emptied, in-flight read is discarded, lane counters are cleared.
  - Reset mid-unload abandons the transfer; nothing resumes after reset.
- Lane order:
  - Canonical Keccak order: lane index i = x + 5*y, i = 0..24, x increments fastest.
  - Sequence is (0,0),(1,0)..(4,0),(0,1)..(4,4).
  - mrx wraps 4->0 with mry+1.
  - After the last issued read, mrx/mry return to 0.
- States:
  - IDLE: start=1 -> ISSUE; busy rises the next cycle.
  - ISSUE: reads are issued under the credit rule. When the final lane (index 24, or RATE_LANES-1) is issued -> DRAIN.
  - DRAIN: waits until the buffer is empty and no read is in flight -> DONE.
  - DONE: done=1 for one cycle, busy falls in the same cycle -> IDLE.
- start while busy is ignored. start in the DONE cycle is also ignored.
- Read issue / credit rule:
  - A read issues in a cycle only if occupancy + inflight - pop <= 1.
  - pop = pushout && !stopout; inflight is 0 or 1.
  - The buffer never overflows, and full throughput is sustained (1 lane/clk) when stopout=0.
- Handshake:
  - A beat transfers on a clk edge where pushout=1 and stopout=0.
  - While stopout=1, pushout, dout and firstout hold stable.
  - pushout never drops without an accepted beat, except on reset.
  - dout, pushout and firstout are registered, driven from the buffer head.
- firstout = 1 only with lane (0,0) data.
- Latency:
  - start sampled at edge T.
  - Address (0,0) is driven in cycle T+1.
  - First beat has pushout=1 in cycle T+3.
  - With stopout=0 throughout: beats occupy T+3..T+27, done in T+28.
- Simultaneous push and pop on the buffer is legal and occupancy is unchanged.
- stopout asserted while pushout=0 has no effect.

Optional Feature:
- Macro PERM_UNLOAD_RATE_EN.
  - Defined: only lanes 0..RATE_LANES-1 are read and emitted (squeeze of the rate portion). done follows the last rate lane. Capacity lanes are never addressed.
  - Not defined: all 25 lanes are emitted; RATE_LANES is unused.

Decomposition:
- Shared package perm_pkg holds:
  - LANE_W
  - NUM_LANES = 25
  - DIM = 5
  - the lane index <-> (x,y) conversion constants
  - the unload state enum (IDLE, ISSUE, DRAIN, DONE)
- One sub-module: perm_skid2, a generic 2-entry valid/stall buffer holding {firstout, lane}. It is reusable by the input side.

Test Plan:
- Memory preloaded with lane(x,y) = 64'hA5A5_0000_0000_0000 | (x+5y); start pulse, stopout=0 -> 25 beats in cycles T+3..T+27 with dout low byte 0..24 in order, firstout only on beat 0, done pulse at T+28.
- stopout=1 for 3 cycles while lane 5 is presented -> dout holds ...05 and pushout stays 1; mrx/mry stop advancing once the buffer is full; stream resumes with 6, no loss or duplication.
- stopout toggling 1/0 every cycle for the whole unload -> exactly 25 accepted beats in order, done once.
- start re-pulsed during unload and in the DONE cycle -> ignored; exactly one 25-beat stream and one done.
- rst asserted at beat 10 -> next cycle pushout=0, busy=0, dout=0; a new start then produces a full stream from (0,0) with firstout.
- PERM_UNLOAD_RATE_EN, RATE_LANES=17 -> beats 0..16 only, mry never exceeds 3, done in cycle T+20.

Source files
------------

// File: rtl/perm_pkg.sv
// Shared constants, lane indexing helpers and the unload state encoding for the permutation block.
package perm_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;
  localparam int DIM       = 5;
  localparam int XY_W      = 3;
  localparam int IDX_W     = 5;

  localparam logic [XY_W-1:0] X_MAX = XY_W'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } unload_state_t;

  // Canonical Keccak lane index i = x + 5*y
  function automatic logic [IDX_W-1:0] lane_index(input logic [XY_W-1:0] x, input logic [XY_W-1:0] y);
    return IDX_W'(x) + IDX_W'(DIM) * IDX_W'(y);
  endfunction

  // Lanes streamed per unload; the rate count is clamped to a legal 1..25
  function automatic int emit_lanes(input bit rate_en, input int rate);
    if (!rate_en) return NUM_LANES;
    if (rate < 1) return 1;
    if (rate > NUM_LANES) return NUM_LANES;
    return rate;
  endfunction

endpackage

// File: rtl/perm_skid2.sv
// Generic 2-entry valid/stall buffer with registered head outputs.
// The writer must never push into a full buffer; the caller's credit logic guarantees that.
module perm_skid2 #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_stall,
  output logic [1:0]   count
);

  logic         head_valid_reg;
  logic         tail_valid_reg;
  logic [W-1:0] head_reg;
  logic [W-1:0] tail_reg;
  logic         pop;

  assign pop = head_valid_reg && !out_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid_reg <= 1'b0;
      tail_valid_reg <= 1'b0;
      head_reg       <= '0;
      tail_reg       <= '0;
    end else if (pop) begin
      if (tail_valid_reg) begin
        head_reg       <= tail_reg;
        tail_valid_reg <= in_valid;
        if (in_valid) tail_reg <= in_data;
      end else begin
        head_valid_reg <= in_valid;
        if (in_valid) head_reg <= in_data;
      end
    end else if (in_valid) begin
      if (!head_valid_reg) begin
        head_reg       <= in_data;
        head_valid_reg <= 1'b1;
      end else begin
        tail_reg       <= in_data;
        tail_valid_reg <= 1'b1;
      end
    end
  end

  assign out_valid = head_valid_reg;
  assign out_data  = head_reg;
  assign count     = {1'b0, head_valid_reg} + {1'b0, tail_valid_reg};

endmodule

// File: rtl/perm_unload.sv
// Streams the final Keccak state out of the state memory in canonical lane order.
// Define PERM_UNLOAD_RATE_EN to emit only the first RATE_LANES lanes (rate squeeze).
module perm_unload #(
  parameter int LANE_W     = 64,
  parameter int RATE_LANES = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [2:0]        mrx,
  output logic [2:0]        mry,
  input  logic [LANE_W-1:0] mrd,
  output logic              pushout,
  input  logic              stopout,
  output logic              firstout,
  output logic [LANE_W-1:0] dout
);

  import perm_pkg::*;

`ifdef PERM_UNLOAD_RATE_EN
  localparam bit RATE_EN = 1'b1;
`else
  localparam bit RATE_EN = 1'b0;
`endif

  localparam int EMIT = emit_lanes(RATE_EN, RATE_LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(EMIT - 1);

  unload_state_t     state_reg, state_next;
  logic [XY_W-1:0]   x_reg, y_reg;
  logic              inflight_reg;
  logic              first_inflight_reg;
  logic              issue, is_last, pop, drained;
  logic [1:0]        occ;
  logic              buf_valid;
  logic [LANE_W:0]   buf_data;

  assign pop     = buf_valid && !stopout;
  assign is_last = (lane_index(x_reg, y_reg) == LAST_IDX);

  // Credit: at most two lanes held or in flight once this cycle's pop is accounted for
  assign issue   = (state_reg == ISSUE) &&
                   (({1'b0, occ} + {2'b0, inflight_reg}) <= (3'd1 + {2'b0, pop}));
  assign drained = !inflight_reg && (occ == {1'b0, pop});

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (issue && is_last) state_next = DRAIN;
      DRAIN:   if (drained) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      ISSUE, DRAIN: busy = 1'b1;
      DONE:         done = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg              <= '0;
      y_reg              <= '0;
      inflight_reg       <= 1'b0;
      first_inflight_reg <= 1'b0;
    end else begin
      inflight_reg       <= issue;
      first_inflight_reg <= issue && (x_reg == '0) && (y_reg == '0);
      if (issue) begin
        if (is_last) begin
          x_reg <= '0;
          y_reg <= '0;
        end else if (x_reg == X_MAX) begin
          x_reg <= '0;
          y_reg <= y_reg + 1'b1;
        end else begin
          x_reg <= x_reg + 1'b1;
        end
      end
    end
  end

  perm_skid2 #(
    .W(LANE_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inflight_reg),
    .in_data  ({first_inflight_reg, mrd}),
    .out_valid(buf_valid),
    .out_data (buf_data),
    .out_stall(stopout),
    .count    (occ)
  );

  assign mrx      = x_reg;
  assign mry      = y_reg;
  assign pushout  = buf_valid;
  assign firstout = buf_data[LANE_W];
  assign dout     = buf_data[LANE_W-1:0];

endmodule

// File: tb/tb_perm_unload.sv
// Bench for perm_unload: scenario table plus reset-abort sequence, checked against a lane-order model.
module tb_perm_unload;

`ifdef PERM_UNLOAD_RATE_EN
  localparam int N_EMIT = 17;
`else
  localparam int N_EMIT = 25;
`endif

  logic        clk = 1'b0;
  logic        rst, start, stopout;
  logic        busy, done, pushout, firstout;
  logic [2:0]  mrx, mry;
  logic [63:0] mrd, dout;
  logic [63:0] mem [25];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int mode;      // 0 no stall, 1 toggle, 2 random, 3 three-cycle stall on lane 5
    bit restart;   // extra start pulses mid-unload and in the done cycle
    bit rand_mem;
    int exp_done;  // 0: cycle not checked
    int exp_first; // 0: cycle not checked
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    int idx;
    idx = int'(mrx) + 5 * int'(mry);
    mrd <= (idx < 25) ? mem[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
  end

  perm_unload dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .mrx     (mrx),
    .mry     (mry),
    .mrd     (mrd),
    .pushout (pushout),
    .stopout (stopout),
    .firstout(firstout),
    .dout    (dout)
  );

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic load_mem(input bit rnd);
    for (int i = 0; i < 25; i++)
      mem[i] = rnd ? {$urandom, $urandom} : (64'hA5A5_0000_0000_0000 | 64'(i));
  endtask

  task automatic run_unload(input int mode, input bit restart, input int exp_done,
                            input int exp_first, input string tag);
    logic [64:0] got[$];
    logic [64:0] prev;
    logic [5:0]  saved;
    logic [2:0]  max_y;
    int cyc, done_cyc, first_cyc, ndone, stall_n;
    bit prev_stall, busy1, busy_at_done, bad_addr, s;
    done_cyc = -1; first_cyc = -1; ndone = 0; stall_n = 0;
    prev_stall = 0; busy_at_done = 1; bad_addr = 0; max_y = 0; saved = '0; prev = '0;
    @(posedge clk); #1;
    start = 1'b1; stopout = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    busy1 = busy;
    while (cyc < 400) begin
      if (prev_stall) begin
        check({tag, "_hold_push"}, 65'(pushout), 65'd1);
        check({tag, "_hold_data"}, {firstout, dout}, prev);
      end
      if (mry > max_y) max_y = mry;
      if (mrx > 3'd4 || mry > 3'd4) bad_addr = 1;
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
      if (pushout && first_cyc < 0) first_cyc = cyc;
      case (mode)
        1:       s = cyc[0];
        2:       s = ($urandom_range(0, 2) == 0);
        default: s = 1'b0;
      endcase
      if (mode == 3 && pushout && got.size() == 5 && stall_n < 3) begin
        s = 1'b1;
        stall_n++;
        if (stall_n == 2) saved = {mrx, mry};
        if (stall_n == 3) check({tag, "_addr_hold"}, 65'({mrx, mry}), 65'(saved));
      end
      start   = restart && (cyc == 10 || done);
      stopout = s;
      if (pushout && !s) got.push_back({firstout, dout});
      prev_stall = pushout && s;
      prev       = {firstout, dout};
      if (done_cyc >= 0 && cyc >= done_cyc + 5) break;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; stopout = 1'b0;
    check({tag, "_done_seen"}, 65'(done_cyc >= 0), 65'd1);
    check({tag, "_done_count"}, 65'(ndone), 65'd1);
    check({tag, "_beats"}, 65'(got.size()), 65'(N_EMIT));
    for (int i = 0; i < N_EMIT; i++)
      if (i < got.size()) check($sformatf("%s_beat%0d", tag, i), got[i], {(i == 0), mem[i]});
    check({tag, "_busy_rise"}, 65'(busy1), 65'd1);
    check({tag, "_busy_at_done"}, 65'(busy_at_done), 65'd0);
    check({tag, "_max_y"}, 65'(max_y), 65'((N_EMIT - 1) / 5));
    check({tag, "_addr_range"}, 65'(bad_addr), 65'd0);
    if (exp_done != 0) check({tag, "_done_cyc"}, 65'(done_cyc), 65'(exp_done));
    if (exp_first != 0) check({tag, "_first_cyc"}, 65'(first_cyc), 65'(exp_first));
    if (mode == 3) check({tag, "_stall_cycles"}, 65'(stall_n), 65'd3);
    $display("unload %s: mode=%0d beats=%0d done_cyc=%0d", tag, mode, got.size(), done_cyc);
  endtask

  task automatic reset_mid();
    int n;
    bit found;
    found = 0;
    load_mem(1'b0);
    @(posedge clk); #1;
    start = 1'b1; stopout = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (n = 0; n < 60; n++) begin
      if (pushout && dout[7:0] == 8'd10) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("rst_reach_beat10", 65'(found), 65'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_pushout", 65'(pushout), 65'd0);
    check("rst_mid_busy", 65'(busy), 65'd0);
    check("rst_mid_dout", 65'(dout), 65'd0);
    check("rst_mid_first", 65'(firstout), 65'd0);
    check("rst_mid_addr", 65'({mrx, mry}), 65'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check("rst_mid_quiet", 65'({pushout, busy, done}), 65'd0);
    end
    $display("reset at beat 10: stream abandoned");
    run_unload(0, 1'b0, N_EMIT + 3, 3, "after_rst");
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 1'b0, N_EMIT + 3, 3};
    vecs[1] = '{3, 1'b0, 1'b0, 0, 3};
    vecs[2] = '{1, 1'b0, 1'b0, 0, 0};
    vecs[3] = '{0, 1'b1, 1'b0, N_EMIT + 3, 3};
    vecs[4] = '{2, 1'b0, 1'b1, 0, 0};
    vecs[5] = '{2, 1'b1, 1'b1, 0, 0};
    vecs[6] = '{0, 1'b0, 1'b1, N_EMIT + 3, 3};

    rst = 1'b1; start = 1'b0; stopout = 1'b0;
    load_mem(1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", 65'(busy), 65'd0);
    check("reset_done", 65'(done), 65'd0);
    check("reset_pushout", 65'(pushout), 65'd0);
    check("reset_first", 65'(firstout), 65'd0);
    check("reset_dout", 65'(dout), 65'd0);
    check("reset_addr", 65'({mrx, mry}), 65'd0);

    stopout = 1'b1;
    @(posedge clk); #1;
    check("idle_stop_noeffect", 65'({pushout, busy, done}), 65'd0);
    stopout = 1'b0;

    for (int v = 0; v < 7; v++) begin
      load_mem(vecs[v].rand_mem);
      run_unload(vecs[v].mode, vecs[v].restart, vecs[v].exp_done, vecs[v].exp_first,
                 $sformatf("vec%0d", v));
    end

    reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
